// File: rtl/vip_axi4_burst_addr_gen.sv
// AXI4 burst address generator: validates one AW/AR command per handshake and
// walks it beat by beat (FIXED / INCR / WRAP), emitting address, strobe, index and last.
module vip_axi4_burst_addr_gen #(
  parameter int ID_WIDTH_P   = 4,
  parameter int ADDR_WIDTH_P = 32,
  parameter int DATA_WIDTH_P = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ID_WIDTH_P-1:0]   cmd_id,
  input  logic [ADDR_WIDTH_P-1:0] cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [ID_WIDTH_P-1:0]   beat_id,
  output logic [ADDR_WIDTH_P-1:0] beat_addr,
  output logic [DATA_WIDTH_P/8-1:0] beat_strb,
  output logic [7:0]              beat_index,
  output logic                    beat_last,
  output logic                    err_valid,
  output logic [3:0]              err_code
);

  localparam int NB  = DATA_WIDTH_P / 8;
  localparam int NBW = $clog2(NB);
  localparam int AW  = ADDR_WIDTH_P;
  localparam int EW  = ADDR_WIDTH_P + 16;

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state_q, state_d;
  logic [ID_WIDTH_P-1:0] id_q, id_d;
  logic [AW-1:0]     addr_q, addr_d, nxt_addr;
  logic [NB-1:0]     strb_q, strb_d;
  logic [7:0]        idx_q, idx_d, len_q, len_d;
  logic              last_q, last_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [AW-1:0]     wmask_q, wmask_d;
  logic              err_valid_q, err_valid_d;
  logic [3:0]        err_code_q, err_code_d;
  logic [3:0]        cmd_err;
  logic              beat_hs, cmd_hs;

  function automatic logic [AW-1:0] size_mask_f(input logic [2:0] size);
    return (AW'(1) << size) - AW'(1);
  endfunction

  // Lanes run from the byte offset of the address to the end of its S-aligned container.
  function automatic logic [NB-1:0] strb_f(input logic [NBW-1:0] lo, input logic [2:0] size);
    logic [NBW:0]   one_sh;
    logic [NBW-1:0] ml;
    logic [NBW:0]   hi;
    logic [NBW:0]   iv;
    logic [NB-1:0]  s;
    one_sh = (NBW+1)'(1) << size;
    ml     = NBW'(one_sh - (NBW+1)'(1));
    hi     = {1'b0, lo & ~ml} + {1'b0, ml};
    s      = '0;
    for (int i = 0; i < NB; i++) begin
      iv   = (NBW+1)'(i);
      s[i] = (iv >= {1'b0, lo}) && (iv <= hi);
    end
    return s;
  endfunction

  function automatic logic [AW-1:0] next_addr_f(input logic [AW-1:0] addr, input logic [2:0] size,
                                                input logic [1:0] burst, input logic [AW-1:0] wmask);
    logic [AW-1:0] m;
    m = size_mask_f(size);
    case (burst)
      2'b00:   return addr;
      2'b10:   return (addr & ~wmask) | ((addr + m + AW'(1)) & wmask);
      default: return (addr & ~m) + m + AW'(1);
    endcase
  endfunction

  // The page check runs in a wider sum so a wrap past the top of the address space also flags.
  function automatic logic [3:0] check_f(input logic [AW-1:0] addr, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    logic [3:0]    e;
    logic [AW-1:0] m;
    logic [EW-1:0] last_byte;
    m         = size_mask_f(size);
    last_byte = EW'(addr & ~m) + ((EW'(len) + EW'(1)) << size) - EW'(1);
    e[0] = size > 3'(NBW);
    e[1] = burst == 2'b11;
    e[2] = ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
           ((burst == 2'b10) && ((addr & m) != '0)) ||
           ((burst == 2'b00) && (len > 8'd15));
    e[3] = (burst == 2'b01) && ((last_byte >> 12) != EW'(addr >> 12));
    return e;
  endfunction

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    strb_d      = strb_q;
    idx_d       = idx_q;
    last_d      = last_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    wmask_d     = wmask_q;
    err_valid_d = 1'b0;
    err_code_d  = '0;
    cmd_err     = check_f(cmd_addr, cmd_len, cmd_size, cmd_burst);
    nxt_addr    = next_addr_f(addr_q, size_q, burst_q, wmask_q);
    beat_hs     = (state_q == BURST) && beat_ready;
    cmd_ready   = !rst && ((state_q == IDLE) || (beat_hs && last_q));
    cmd_hs      = cmd_valid && cmd_ready;

    if (beat_hs) begin
      if (last_q) begin
        state_d = IDLE;
      end else begin
        addr_d = nxt_addr;
        strb_d = strb_f(nxt_addr[NBW-1:0], size_q);
        idx_d  = idx_q + 8'd1;
        last_d = (idx_q + 8'd1) == len_q;
      end
    end

    if (cmd_hs) begin
      if (|cmd_err) begin
        err_valid_d = 1'b1;
        err_code_d  = cmd_err;
      end else begin
        state_d = BURST;
        id_d    = cmd_id;
        addr_d  = cmd_addr;
        strb_d  = strb_f(cmd_addr[NBW-1:0], cmd_size);
        idx_d   = 8'd0;
        last_d  = cmd_len == 8'd0;
        len_d   = cmd_len;
        size_d  = cmd_size;
        burst_d = cmd_burst;
        wmask_d = ((AW'(cmd_len) + AW'(1)) << cmd_size) - AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      strb_q      <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      wmask_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      strb_q      <= strb_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      wmask_q     <= wmask_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign beat_valid = state_q == BURST;
  assign beat_id    = id_q;
  assign beat_addr  = addr_q;
  assign beat_strb  = strb_q;
  assign beat_index = idx_q;
  assign beat_last  = last_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_vip_axi4_burst_addr_gen.sv
// Directed bench for vip_axi4_burst_addr_gen (64-bit data, 32-bit address):
// a vector table for single commands plus sequences for stall, back-to-back and reset.
module tb_vip_axi4_burst_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [3:0]  beat_id;
  logic [31:0] beat_addr;
  logic [7:0]  beat_strb;
  logic [7:0]  beat_index;
  logic        beat_last;
  logic        err_valid;
  logic [3:0]  err_code;

  int checks   = 0;
  int failures = 0;

  vip_axi4_burst_addr_gen #(.ID_WIDTH_P(4), .ADDR_WIDTH_P(32), .DATA_WIDTH_P(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id), .beat_addr(beat_addr),
    .beat_strb(beat_strb), .beat_index(beat_index), .beat_last(beat_last),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [3:0]        id;
    logic [3:0]        err;
    int                nb;
    logic [3:0][31:0]  eaddr;
    logic [3:0][7:0]   estrb;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_size  = s;
    cmd_burst = b;
    cmd_id    = id;
  endtask

  task automatic run_vec(input vec_t v);
    beat_ready = 1'b1;
    drive_cmd(v.addr, v.len, v.size, v.burst, v.id);
    #1;
    chk({v.name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    if (v.err != 4'd0) begin
      chk({v.name, "_err_valid"}, 64'(err_valid), 64'd1);
      chk({v.name, "_err_code"}, 64'(err_code), 64'(v.err));
      chk({v.name, "_no_beat"}, 64'(beat_valid), 64'd0);
      step();
      chk({v.name, "_err_pulse_end"}, 64'(err_valid), 64'd0);
      chk({v.name, "_no_beat_after"}, 64'(beat_valid), 64'd0);
    end else begin
      for (int k = 0; k < v.nb; k++) begin
        chk({v.name, "_valid"}, 64'(beat_valid), 64'd1);
        chk({v.name, "_addr"}, 64'(beat_addr), 64'(v.eaddr[k]));
        chk({v.name, "_strb"}, 64'(beat_strb), 64'(v.estrb[k]));
        chk({v.name, "_index"}, 64'(beat_index), 64'(k));
        chk({v.name, "_last"}, 64'(beat_last), 64'(k == v.nb - 1));
        chk({v.name, "_id"}, 64'(beat_id), 64'(v.id));
        chk({v.name, "_no_err"}, 64'(err_valid), 64'd0);
        step();
      end
      chk({v.name, "_done"}, 64'(beat_valid), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int guard;
    logic [31:0] base;

    vecs[0]  = '{"incr_aligned", 32'h1000, 8'd3, 3'd3, 2'b01, 4'd3, 4'b0000, 4,
                 {32'h1018, 32'h1010, 32'h1008, 32'h1000}, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[1]  = '{"incr_unaligned", 32'h1003, 8'd1, 3'd2, 2'b01, 4'd4, 4'b0000, 2,
                 {32'h0, 32'h0, 32'h1004, 32'h1003}, {8'h00, 8'h00, 8'hF0, 8'h08}};
    vecs[2]  = '{"wrap_4x8", 32'h38, 8'd3, 3'd3, 2'b10, 4'd5, 4'b0000, 4,
                 {32'h30, 32'h28, 32'h20, 32'h38}, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[3]  = '{"fixed_3x4", 32'h104, 8'd2, 3'd2, 2'b00, 4'd6, 4'b0000, 3,
                 {32'h0, 32'h104, 32'h104, 32'h104}, {8'h00, 8'hF0, 8'hF0, 8'hF0}};
    vecs[4]  = '{"wrap_2x4", 32'h104, 8'd1, 3'd2, 2'b10, 4'd7, 4'b0000, 2,
                 {32'h0, 32'h0, 32'h100, 32'h104}, {8'h00, 8'h00, 8'h0F, 8'hF0}};
    vecs[5]  = '{"err_4k", 32'hFF8, 8'd1, 3'd3, 2'b01, 4'd1, 4'b1000, 0, '0, '0};
    vecs[6]  = '{"err_burst11", 32'h0, 8'd0, 3'd0, 2'b11, 4'd1, 4'b0010, 0, '0, '0};
    vecs[7]  = '{"err_size", 32'h0, 8'd0, 3'd4, 2'b01, 4'd1, 4'b0001, 0, '0, '0};
    vecs[8]  = '{"err_wrap_len", 32'h0, 8'd2, 3'd3, 2'b10, 4'd1, 4'b0100, 0, '0, '0};
    vecs[9]  = '{"err_top_wrap", 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 4'd1, 4'b1000, 0, '0, '0};
    vecs[10] = '{"err_combo", 32'h0, 8'd0, 3'd4, 2'b11, 4'd1, 4'b0011, 0, '0, '0};
    vecs[11] = '{"err_wrap_unal", 32'h6, 8'd1, 3'd2, 2'b10, 4'd1, 4'b0100, 0, '0, '0};
    vecs[12] = '{"err_fixed_len", 32'h0, 8'd16, 3'd0, 2'b00, 4'd1, 4'b0100, 0, '0, '0};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_id = '0;
    cmd_addr = '0;
    cmd_len = '0;
    cmd_size = '0;
    cmd_burst = '0;
    beat_ready = 1'b1;
    step();
    step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_beat_valid", 64'(beat_valid), 64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_beat_addr", 64'(beat_addr), 64'd0);
    chk("rst_beat_strb", 64'(beat_strb), 64'd0);
    chk("rst_beat_index", 64'(beat_index), 64'd0);
    chk("rst_beat_last", 64'(beat_last), 64'd0);
    chk("rst_beat_id", 64'(beat_id), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    step();

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Random backpressure on an 8-beat INCR: outputs must hold while stalled.
    base = 32'h2000;
    drive_cmd(base, 8'd7, 3'd3, 2'b01, 4'd9);
    step();
    cmd_valid = 1'b0;
    k = 0;
    guard = 0;
    while (k < 8 && guard < 200) begin
      beat_ready = (guard < 2) ? 1'b0 : 1'(($urandom_range(0, 1)));
      #1;
      chk("bp_valid", 64'(beat_valid), 64'd1);
      chk("bp_addr", 64'(beat_addr), 64'(base + 32'(k) * 32'd8));
      chk("bp_index", 64'(beat_index), 64'(k));
      chk("bp_last", 64'(beat_last), 64'(k == 7));
      if (beat_ready) k++;
      guard++;
      step();
    end
    chk("bp_all_beats_seen", 64'(k), 64'd8);
    beat_ready = 1'b1;
    #1;
    chk("bp_done", 64'(beat_valid), 64'd0);
    step();

    // Back-to-back: second command waits while not ready, then lands with no gap.
    drive_cmd(32'h3000, 8'd1, 3'd3, 2'b01, 4'd1);
    step();
    drive_cmd(32'h4000, 8'd0, 3'd3, 2'b01, 4'd2);
    #1;
    chk("b2b_hold_ready", 64'(cmd_ready), 64'd0);
    chk("b2b_a0_addr", 64'(beat_addr), 64'h3000);
    step();
    chk("b2b_a1_addr", 64'(beat_addr), 64'h3008);
    chk("b2b_a1_last", 64'(beat_last), 64'd1);
    chk("b2b_accept_ready", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    chk("b2b_b0_valid", 64'(beat_valid), 64'd1);
    chk("b2b_b0_addr", 64'(beat_addr), 64'h4000);
    chk("b2b_b0_id", 64'(beat_id), 64'd2);
    chk("b2b_b0_index", 64'(beat_index), 64'd0);
    chk("b2b_b0_last", 64'(beat_last), 64'd1);
    step();
    chk("b2b_done", 64'(beat_valid), 64'd0);

    // Reset during beat 2 of an 8-beat burst, then a single-beat command.
    drive_cmd(32'h5000, 8'd7, 3'd3, 2'b01, 4'd3);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("rmid_index", 64'(beat_index), 64'd2);
    chk("rmid_addr", 64'(beat_addr), 64'h5010);
    rst = 1'b1;
    step();
    chk("rmid_valid_dropped", 64'(beat_valid), 64'd0);
    chk("rmid_no_err", 64'(err_valid), 64'd0);
    chk("rmid_ready_low", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rmid_ready_after", 64'(cmd_ready), 64'd1);
    drive_cmd(32'h6000, 8'd0, 3'd2, 2'b01, 4'd7);
    step();
    cmd_valid = 1'b0;
    chk("rlen0_valid", 64'(beat_valid), 64'd1);
    chk("rlen0_addr", 64'(beat_addr), 64'h6000);
    chk("rlen0_strb", 64'(beat_strb), 64'h0F);
    chk("rlen0_last", 64'(beat_last), 64'd1);
    chk("rlen0_id", 64'(beat_id), 64'd7);
    step();
    chk("rlen0_single", 64'(beat_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
